// File: rtl/ddr_rdata_checker.sv
// ddr_rdata_checker: compares one DDR2 read burst, beat by beat, against the
// tag/index pattern written by the traffic generator. Reports the error count,
// the first failing beat, pass/fail and timeout per run, a sticky stray-beat
// flag, and saturating run/fail totals.
module ddr_rdata_checker #(
   parameter int BURST_LEN      = 256,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        chk_start,
   input  logic [7:0]  chk_tag,
   input  logic        rdata_valid,
   input  logic [63:0] rdata,
   output logic        chk_busy,
   output logic        chk_done,
   output logic        chk_pass,
   output logic        chk_timeout,
   output logic [8:0]  err_cnt,
   output logic [7:0]  first_err_idx,
   output logic [63:0] first_err_data,
   output logic        stray_beat,
   output logic [15:0] run_cnt,
   output logic [15:0] fail_cnt
);

   // Idle counter only has to reach TIMEOUT_CYCLES-2: the timeout decision is
   // taken on the last idle cycle, so chk_done lands TIMEOUT_CYCLES cycles
   // after the last beat (or after the start pulse).
   localparam int              TW         = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [7:0]      LAST_IDX   = 8'(BURST_LEN - 1);
   localparam logic [TW-1:0]   IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 2);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [7:0]    tag_q;
   logic [7:0]    idx_q;
   logic [TW-1:0] idle_q;
   logic          busy_q;
   logic          done_q;
   logic          pass_q;
   logic          timeout_q;
   logic [8:0]    err_cnt_q;
   logic [7:0]    first_idx_q;
   logic [63:0]   first_data_q;
   logic          stray_q;
   logic [15:0]   run_cnt_q;
   logic [15:0]   fail_cnt_q;

   logic          beat_bad;
   logic          pass_d;
   logic [15:0]   run_cnt_d;
   logic [15:0]   fail_cnt_d;

   // Four 16-bit lanes of {tag, index[5:0], lane}, lane 00 in the MSB lane.
   function automatic logic [63:0] expected_word(input logic [7:0] t, input logic [5:0] i);
      return {t, i, 2'b00, t, i, 2'b01, t, i, 2'b10, t, i, 2'b11};
   endfunction

   // Run/fail totals stick at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Beat compare and end-of-run result/totals, consumed by the FSM.
   always_comb begin
      beat_bad   = 1'b0;
      pass_d     = 1'b0;
      run_cnt_d  = run_cnt_q;
      fail_cnt_d = fail_cnt_q;
      beat_bad   = (rdata != expected_word(tag_q, idx_q[5:0]));
      pass_d     = (err_cnt_q == 9'd0) && !timeout_q;
      run_cnt_d  = sat_inc16(run_cnt_q);
      fail_cnt_d = pass_d ? fail_cnt_q : sat_inc16(fail_cnt_q);
   end

   // Run-control FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         tag_q        <= '0;
         idx_q        <= '0;
         idle_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         timeout_q    <= 1'b0;
         err_cnt_q    <= '0;
         first_idx_q  <= '0;
         first_data_q <= '0;
         stray_q      <= 1'b0;
         run_cnt_q    <= '0;
         fail_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         // A beat outside RUN (including one coincident with chk_start) is stray.
         if (rdata_valid && (state_q != S_RUN)) begin
            stray_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (chk_start) begin
                  tag_q        <= chk_tag;
                  idx_q        <= '0;
                  idle_q       <= '0;
                  err_cnt_q    <= '0;
                  first_idx_q  <= '0;
                  first_data_q <= '0;
                  timeout_q    <= 1'b0;
                  pass_q       <= 1'b0;
                  busy_q       <= 1'b1;
                  state_q      <= S_RUN;
               end
            end
            S_RUN: begin
               if (rdata_valid) begin
                  idx_q  <= idx_q + 8'd1;
                  idle_q <= '0;
                  if (beat_bad) begin
                     err_cnt_q <= err_cnt_q + 9'd1;
                     if (err_cnt_q == 9'd0) begin
                        first_idx_q  <= idx_q;
                        first_data_q <= rdata;
                     end
                  end
                  if (idx_q == LAST_IDX) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end
               end else if (idle_q == IDLE_LIMIT) begin
                  timeout_q <= 1'b1;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end else begin
                  idle_q <= idle_q + TW'(1);
               end
            end
            S_DONE: begin
               pass_q     <= pass_d;
               run_cnt_q  <= run_cnt_d;
               fail_cnt_q <= fail_cnt_d;
               busy_q     <= 1'b0;
               state_q    <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign chk_busy       = busy_q;
   assign chk_done       = done_q;
   assign chk_pass       = pass_q;
   assign chk_timeout    = timeout_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_idx  = first_idx_q;
   assign first_err_data = first_data_q;
   assign stray_beat     = stray_q;
   assign run_cnt        = run_cnt_q;
   assign fail_cnt       = fail_cnt_q;

endmodule

// File: tb/tb_ddr_rdata_checker.sv
// Scoreboard bench for ddr_rdata_checker: drivers push expected run results,
// monitors pop them when chk_done fires and check the post-run totals.
module tb_ddr_rdata_checker;

   localparam int TO  = 4096;
   localparam int TO1 = 16;

   typedef struct {
      int          done_cyc;
      int          errs;
      int          first_idx;
      logic [63:0] first_data;
      bit          tmo;
      bit          pass;
      int          run;
      int          fail;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   // main instance signals
   logic        start0, vld0;
   logic [7:0]  tag0;
   logic [63:0] data0;
   logic        busy0, done0, pass0, tmo0, stray0;
   logic [8:0]  ec0;
   logic [7:0]  fidx0;
   logic [63:0] fdata0;
   logic [15:0] run0, fail0;

   // BURST_LEN=1 instance signals
   logic        start1, vld1;
   logic [7:0]  tag1;
   logic [63:0] data1;
   logic        busy1, done1, pass1, tmo1, stray1;
   logic [8:0]  ec1;
   logic [7:0]  fidx1;
   logic [63:0] fdata1;
   logic [15:0] run1, fail1;

   exp_t q0[$];
   exp_t q1[$];
   bit   pend0 = 1'b0;
   bit   pend1 = 1'b0;
   int   m_run = 0, m_fail = 0, m1_run = 0, m1_fail = 0;

   ddr_rdata_checker #(.BURST_LEN(256), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .rst_n(rst_n), .chk_start(start0), .chk_tag(tag0),
      .rdata_valid(vld0), .rdata(data0), .chk_busy(busy0), .chk_done(done0),
      .chk_pass(pass0), .chk_timeout(tmo0), .err_cnt(ec0), .first_err_idx(fidx0),
      .first_err_data(fdata0), .stray_beat(stray0), .run_cnt(run0), .fail_cnt(fail0)
   );

   ddr_rdata_checker #(.BURST_LEN(1), .TIMEOUT_CYCLES(TO1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .chk_start(start1), .chk_tag(tag1),
      .rdata_valid(vld1), .rdata(data1), .chk_busy(busy1), .chk_done(done1),
      .chk_pass(pass1), .chk_timeout(tmo1), .err_cnt(ec1), .first_err_idx(fidx1),
      .first_err_data(fdata1), .stray_beat(stray1), .run_cnt(run1), .fail_cnt(fail1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600000;
      $display("FAIL watchdog: simulation still running at cycle %0d, required finish earlier", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference pattern, built lane by lane from the tag/index rule.
   function automatic logic [63:0] pat(input logic [7:0] t, input int i);
      logic [63:0] w;
      logic [7:0]  ib;
      ib = 8'(i);
      w  = '0;
      for (int l = 0; l < 4; l++) w[63-16*l -: 16] = {t, ib[5:0], 2'(l)};
      return w;
   endfunction

   function automatic int sat16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, busy0, 0);
      check({tag, "_done"}, done0, 0);
      check({tag, "_pass"}, pass0, 0);
      check({tag, "_timeout"}, tmo0, 0);
      check({tag, "_err_cnt"}, ec0, 0);
      check({tag, "_first_idx"}, fidx0, 0);
      check({tag, "_first_data"}, fdata0, 0);
      check({tag, "_stray"}, stray0, 0);
      check({tag, "_run_cnt"}, run0, 0);
      check({tag, "_fail_cnt"}, fail0, 0);
   endtask

   // One run on the main instance; nbeats < 256 only for the timeout case.
   task automatic do_run(input logic [7:0] tag, input int nbeats, input int max_gap,
                         input int corrupt_idx, input int pct, input bit tmo,
                         input int ign_at, input bit start_with_vld);
      exp_t        e;
      int          errs, first, last, gap;
      logic [63:0] fdata, d;
      errs = 0; first = 0; fdata = '0; last = 0;
      @(negedge clk);
      start0 = 1'b1; tag0 = tag; vld0 = start_with_vld; data0 = pat(tag, 0);
      for (int i = 0; i < nbeats; i++) begin
         gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            start0 = 1'b0; vld0 = 1'b0; data0 = 64'($urandom);
         end
         @(negedge clk);
         start0 = (i == ign_at);
         tag0   = (i == ign_at) ? 8'hAA : tag;
         d = pat(tag, i);
         if (i == corrupt_idx) d = d ^ 64'h1;
         if (pct > 0 && $urandom_range(0, 99) < pct) d = d ^ (64'h1 << $urandom_range(0, 63));
         if (d != pat(tag, i)) begin
            if (errs == 0) begin first = i; fdata = d; end
            errs++;
         end
         vld0 = 1'b1; data0 = d;
         last = cyc;
      end
      e.done_cyc   = last + (tmo ? TO : 1);
      e.errs       = errs;
      e.first_idx  = first;
      e.first_data = fdata;
      e.tmo        = tmo;
      e.pass       = (errs == 0) && !tmo;
      m_run        = sat16(m_run + 1);
      if (!e.pass) m_fail = sat16(m_fail + 1);
      e.run  = m_run;
      e.fail = m_fail;
      q0.push_back(e);
      @(negedge clk);
      start0 = 1'b0; vld0 = 1'b0;
      if (tmo) repeat (TO - 1) @(negedge clk);
   endtask

   // One BURST_LEN=1 run on the second instance.
   task automatic run_one(input bit bad);
      exp_t        e;
      logic [7:0]  t;
      logic [63:0] d;
      t = 8'($urandom);
      @(negedge clk);
      start1 = 1'b1; tag1 = t; vld1 = 1'b0;
      @(negedge clk);
      start1 = 1'b0;
      d = pat(t, 0);
      if (bad) d = d ^ (64'h1 << $urandom_range(0, 63));
      vld1 = 1'b1; data1 = d;
      e.done_cyc = cyc + 1;
      e.errs = bad ? 1 : 0;
      e.first_idx = 0;
      e.first_data = bad ? d : 64'h0;
      e.tmo = 1'b0;
      e.pass = !bad;
      m1_run = sat16(m1_run + 1);
      if (bad) m1_fail = sat16(m1_fail + 1);
      e.run = m1_run;
      e.fail = m1_fail;
      q1.push_back(e);
      @(negedge clk);
      vld1 = 1'b0;
   endtask

   // Main-instance monitor.
   initial begin
      exp_t p;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend0 = 1'b0;
         end else begin
            if (pend0) begin
               check("pass", pass0, p.pass);
               check("run_cnt", run0, p.run);
               check("fail_cnt", fail0, p.fail);
               check("busy_after_done", busy0, 0);
               pend0 = 1'b0;
            end
            if (done0) begin
               if (q0.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: chk_done=1 at cycle %0d, required no pulse", cyc);
               end else begin
                  p = q0.pop_front();
                  check("done_cycle", cyc, p.done_cyc);
                  check("err_cnt", ec0, p.errs);
                  check("first_err_idx", fidx0, p.first_idx);
                  check("first_err_data", fdata0, p.first_data);
                  check("timeout", tmo0, p.tmo);
                  check("busy_in_done", busy0, 1);
                  pend0 = 1'b1;
               end
            end
         end
      end
   end

   // BURST_LEN=1 instance monitor.
   initial begin
      exp_t p;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend1 = 1'b0;
         end else begin
            if (pend1) begin
               check("u1_pass", pass1, p.pass);
               check("u1_run_cnt", run1, p.run);
               check("u1_fail_cnt", fail1, p.fail);
               pend1 = 1'b0;
            end
            if (done1) begin
               if (q1.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL u1_unexpected_done: chk_done=1 at cycle %0d, required no pulse", cyc);
               end else begin
                  p = q1.pop_front();
                  check("u1_done_cycle", cyc, p.done_cyc);
                  check("u1_err_cnt", ec1, p.errs);
                  check("u1_first_err_data", fdata1, p.first_data);
                  pend1 = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      start0 = 1'b0; vld0 = 1'b0; tag0 = '0; data0 = '0;
      start1 = 1'b0; vld1 = 1'b0; tag1 = '0; data1 = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("post_reset");

      // clean contiguous burst
      do_run(8'h05, 256, 0, -1, 0, 1'b0, -1, 1'b0);
      // beat 17 corrupted, random gaps below 100 cycles
      do_run(8'h05, 256, 99, 17, 0, 1'b0, -1, 1'b0);
      // random tags, random corruptions, short gaps, back-to-back
      for (int r = 0; r < 3; r++) do_run(8'($urandom), 256, 3, -1, 4, 1'b0, -1, 1'b0);
      // timeout after 10 good beats
      do_run(8'h5A, 10, 0, -1, 0, 1'b1, -1, 1'b0);

      // stray beat while idle
      @(negedge clk);
      check("stray_before", stray0, 0);
      vld0 = 1'b1; data0 = pat(8'h3C, 0);
      @(negedge clk);
      vld0 = 1'b0;
      check("stray_idle_beat", stray0, 1);
      // beat coincident with start is stray; second start with tag AA is ignored
      do_run(8'h3C, 256, 2, -1, 0, 1'b0, 5, 1'b1);
      check("stray_sticky", stray0, 1);

      // reset at beat 100
      @(negedge clk);
      start0 = 1'b1; tag0 = 8'h77;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start0 = 1'b0; vld0 = 1'b1; data0 = pat(8'h77, i);
      end
      @(negedge clk);
      vld0 = 1'b0;
      rst_n = 1'b0;
      m_run = 0; m_fail = 0; m1_run = 0; m1_fail = 0;
      #1;
      check_zero("mid_run_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("no_done_after_reset", done0, 0);
      check("busy_after_reset", busy0, 0);
      do_run(8'h77, 256, 1, -1, 0, 1'b0, -1, 1'b0);

      // saturation on the BURST_LEN=1 instance
      run_one(1'b0);
      run_one(1'b1);
      @(negedge clk);
      force u_dut1.run_cnt_q = 16'hFFFC;
      force u_dut1.fail_cnt_q = 16'hFFFB;
      #1;
      release u_dut1.run_cnt_q;
      release u_dut1.fail_cnt_q;
      m1_run = 16'hFFFC; m1_fail = 16'hFFFB;
      run_one(1'b1);
      run_one(1'b0);
      for (int r = 0; r < 7; r++) run_one(1'b1);

      // drain with a bounded wait
      for (int w = 0; w < 50; w++) begin
         if (q0.size() == 0 && q1.size() == 0 && !pend0 && !pend1) break;
         @(negedge clk);
      end
      check("queue0_drained", q0.size() + pend0, 0);
      check("queue1_drained", q1.size() + pend1, 0);
      check("final_run_cnt1", run1, 16'hFFFF);
      check("final_fail_cnt1", fail1, 16'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ddr_rdata_checker.md
# ddr_rdata_checker

- Sits directly downstream of the DDR2 controller read-data port, in parallel with the on-chip capture RAM.
- Consumes the 64-bit `rdata`/`rdata_valid` beat stream of one read burst and compares every beat against the pattern the traffic generator wrote.
- Counts mismatches, captures the first failing beat, and reports pass/fail per run, plus saturating run/fail totals for LEDs or SignalTap.
- Started by the same one-cycle pulse that launches the read phase.

## Interface
Parameters:
- BURST_LEN, 256: beats per check run; legal range 1..256.
- TIMEOUT_CYCLES, 4096: maximum idle cycles allowed between start and the first beat, or between two beats.

Ports:
- clk  in  1  system clock (controller local clock, 75 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- chk_start  in  1  one-cycle pulse that arms a run.
- chk_tag  in  8  expected tag byte; sampled on chk_start.
- rdata_valid  in  1  read beat strobe from the controller.
- rdata  in  64  read beat data.
- chk_busy  out  1  run in progress.
- chk_done  out  1  one-cycle pulse marking the end of a run.
- chk_pass  out  1  result of the last run; held until the next chk_start.
- chk_timeout  out  1  last run ended by timeout.
- err_cnt  out  9  mismatching beats in the last or current run.
- first_err_idx  out  8  beat index of the first mismatch.
- first_err_data  out  64  rdata of the first mismatch.
- stray_beat  out  1  sticky: a valid beat arrived while not busy.
- run_cnt  out  16  completed runs, saturating.
- fail_cnt  out  16  failed runs, saturating.

## Operation
- **Expected word for beat i** (i = 8-bit beat index, t = latched tag):
  - {t, i[5:0],2'b00, t, i[5:0],2'b01, t, i[5:0],2'b10, t, i[5:0],2'b11}.
  - Bits [63:56] hold t; lane suffixes 00/01/10/11 run from the MSB lane down to the LSB lane.
- **FSM: IDLE, RUN, DONE.**
  - IDLE: when chk_start=1:
    - latch chk_tag;
    - clear idx, err_cnt, first_err_idx, first_err_data, chk_timeout, chk_pass, and the idle counter;
    - go to RUN.
  - RUN, on each rdata_valid:
    - compare rdata with the expected word for idx, then idx <= idx+1;
    - on mismatch, err_cnt <= err_cnt+1;
    - on the first mismatch (err_cnt==0), also capture idx and rdata.
  - RUN, end of burst: when a valid beat arrives with idx==BURST_LEN-1, go to DONE after that beat's compare.
  - RUN, idle counter:
    - increments on every cycle without rdata_valid and clears on a beat;
    - when it reaches TIMEOUT_CYCLES-1 without a beat, set chk_timeout=1 and go to DONE.
  - DONE, one cycle:
    - chk_pass <= (err_cnt==0) && !chk_timeout;
    - run_cnt +1; fail_cnt +1 if not passing (both saturate at 16'hFFFF);
    - go to IDLE.
- chk_start while in RUN or DONE is ignored; the tag is not re-latched.
- rdata_valid in IDLE or DONE: the beat is not compared and stray_beat is set. stray_beat clears only on reset.
- rdata_valid on the same cycle as chk_start in IDLE is treated as stray; beat 0 must arrive no earlier than the cycle after chk_start.
- Reset mid-run: all state returns to reset values immediately; no done pulse is issued.

## Timing
- Reset values:
  - cstate=IDLE; all outputs 0, including chk_pass=0 and every counter.
- chk_busy=1 from the cycle after chk_start through the DONE cycle.
- err_cnt, first_err_* are registered and update on the clock edge that samples the beat (visible next cycle).
- chk_done=1 for exactly the DONE cycle, i.e. the cycle after the edge that samples the final beat or the timeout.
- chk_pass, run_cnt and fail_cnt become valid the cycle after chk_done.
- Back-to-back runs: chk_start is accepted in the first IDLE cycle after DONE.
- Beats may arrive every cycle with no throughput limit; gaps of any length below TIMEOUT_CYCLES are legal.
- Index and widths:
  - idx is 8 bits and wraps only by design at BURST_LEN=256;
  - err_cnt reaches at most 256 and needs 9 bits.

## Test plan
- **Clean burst, contiguous.** Start with tag 8'h05, then 256 contiguous beats of the correct pattern. Required: err_cnt=0, chk_done one cycle after beat 255, chk_pass=1, run_cnt=1, fail_cnt=0.
- **Single corrupted beat.** Same run with beat 17 XORed with 64'h1 under random valid gaps (<100 cycles). Required: err_cnt=1, first_err_idx=17, first_err_data = corrupted word, chk_pass=0, fail_cnt=1.
- **Timeout.** Start, send 10 correct beats, then stop. Required: chk_done exactly TIMEOUT_CYCLES cycles after the last beat, chk_timeout=1, err_cnt=0, chk_pass=0.
- **Stray traffic and ignored start.** A valid beat while IDLE, then a second chk_start during RUN with tag 8'hAA. Required: stray_beat=1; the run still checks against the original tag and passes.
- **Reset mid-run.** Assert rst_n=0 at beat 100. Required: all outputs 0, no chk_done; a subsequent full clean run passes with run_cnt=1.
- **Saturation.** Force 65537 consecutive short failing runs (BURST_LEN=1 build). Required: run_cnt and fail_cnt hold 16'hFFFF.
